axis_channel_dispatch: RTL and testbench

AXIS_CHANNEL_DISPATCH -- requirements
Module: axis_channel_dispatch

---
 rtl/dispatch_pkg.sv | 12 +
 rtl/rr_next_sel.sv | 19 +
 rtl/axis_channel_dispatch.sv | 97 +++++++++
 tb/tb_axis_channel_dispatch.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/dispatch_pkg.sv
// dispatch_pkg: FSM state encoding and default width constants shared by the channel dispatcher
package dispatch_pkg;
  typedef enum logic [1:0] {IDLE, ROUTE, DRAIN, DONE} state_t;
  localparam int CHANNEL_DEF = 4;
  localparam int DATA_WIDTH_DEF = 64;
  localparam int PKT_CNT_W_DEF = 16;
`ifdef DISPATCH_STATS_EN
  localparam bit STATS_EN = 1'b1;
`else
  localparam bit STATS_EN = 1'b0;
`endif
endpackage

// File: rtl/rr_next_sel.sv
// rr_next_sel: next enabled channel strictly after sel (wrapping); ports mask, sel -> next_sel; returns sel when it is the only enabled channel
module rr_next_sel #(
  parameter int Channel = 4,
  parameter int SW = (Channel > 1) ? $clog2(Channel) : 1
) (
  input  logic [Channel-1:0] mask,
  input  logic [SW-1:0]      sel,
  output logic [SW-1:0]      next_sel
);
  logic [SW-1:0] idx;
  always_comb begin
    next_sel = sel;
    idx = '0;
    for (int k = Channel; k >= 1; k--) begin
      idx = SW'((int'(sel) + k) % Channel);
      if (mask[idx]) next_sel = idx;
    end
  end
endmodule

// File: rtl/axis_channel_dispatch.sv
// axis_channel_dispatch: routes whole AXIS packets round-robin over the enabled output channels.
// Ports: s_axis_aclk/s_axis_aresetn (async active-low); i_start/i_ch_en/i_pkt_num job setup; i_tx_done downstream drained;
// s_axis_* single upstream stream; m_axis_* per-channel streams, channel i at [i*DATA_WIDTH+:DATA_WIDTH];
// o_busy, o_done, o_err status; o_word_cnt per-channel accepted-beat counters when DISPATCH_STATS_EN is defined.
module axis_channel_dispatch
  import dispatch_pkg::*;
#(
  parameter int Channel = CHANNEL_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int PKT_CNT_W = PKT_CNT_W_DEF
) (
  input  logic                          s_axis_aclk,
  input  logic                          s_axis_aresetn,
  input  logic                          i_start,
  input  logic [Channel-1:0]            i_ch_en,
  input  logic [PKT_CNT_W-1:0]          i_pkt_num,
  input  logic                          i_tx_done,
  output logic                          s_axis_tready,
  input  logic [DATA_WIDTH-1:0]         s_axis_tdata,
  input  logic                          s_axis_tlast,
  input  logic                          s_axis_tvalid,
  input  logic [Channel-1:0]            m_axis_tready,
  output logic [Channel*DATA_WIDTH-1:0] m_axis_tdata,
  output logic [Channel-1:0]            m_axis_tlast,
  output logic [Channel-1:0]            m_axis_tvalid,
  output logic                          o_busy,
  output logic                          o_done,
  output logic                          o_err
`ifdef DISPATCH_STATS_EN
  ,
  output logic [Channel*32-1:0]         o_word_cnt
`endif
);
  localparam int SW = (Channel > 1) ? $clog2(Channel) : 1;
  state_t state, state_nxt;
  logic [SW-1:0] sel, adv_sel, first_sel;
  logic [Channel-1:0] ch_en_r;
  logic [PKT_CNT_W-1:0] pkt_num_r, pkt_cnt;
  logic err_r, start_ok, fire, last_hs;
  assign start_ok = state == IDLE && i_start && |i_ch_en;
  assign fire = s_axis_tvalid && s_axis_tready;
  assign last_hs = fire && s_axis_tlast;
  // Searching after Channel-1 wraps to the lowest enabled channel of the incoming mask.
  rr_next_sel #(.Channel(Channel), .SW(SW)) u_first (.mask(i_ch_en), .sel(SW'(Channel - 1)), .next_sel(first_sel));
  rr_next_sel #(.Channel(Channel), .SW(SW)) u_adv (.mask(ch_en_r), .sel(sel), .next_sel(adv_sel));
  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn)
    if (!s_axis_aresetn) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (start_ok) state_nxt = (i_pkt_num == '0) ? DONE : ROUTE;
      ROUTE: if (last_hs && pkt_cnt == pkt_num_r - PKT_CNT_W'(1)) state_nxt = DRAIN;
      DRAIN: if (i_tx_done) state_nxt = DONE;
      DONE:  state_nxt = IDLE;
    endcase
  end
  // sel only moves on a tlast handshake, so a packet never straddles channels.
  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn)
    if (!s_axis_aresetn) begin
      sel <= '0;
      ch_en_r <= '0;
      pkt_num_r <= '0;
      pkt_cnt <= '0;
      err_r <= 1'b0;
    end else begin
      if (state == IDLE && i_start) err_r <= ~|i_ch_en;
      if (start_ok) begin
        ch_en_r <= i_ch_en;
        pkt_num_r <= i_pkt_num;
        pkt_cnt <= '0;
        sel <= first_sel;
      end else if (last_hs) begin
        pkt_cnt <= pkt_cnt + PKT_CNT_W'(pkt_cnt != '1);
        sel <= adv_sel;
      end
    end
  always_comb begin
    s_axis_tready = state == ROUTE && m_axis_tready[sel];
    m_axis_tvalid = (state == ROUTE && s_axis_tvalid) ? Channel'(1) << sel : '0;
    m_axis_tdata = {Channel{s_axis_tdata}};
    m_axis_tlast = {Channel{s_axis_tlast}};
    o_busy = state != IDLE;
    o_done = state == DONE;
    o_err = err_r;
  end
`ifdef DISPATCH_STATS_EN
  for (genvar c = 0; c < Channel; c++) begin : g_stat
    logic [31:0] cnt;
    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn)
      if (!s_axis_aresetn) cnt <= '0;
      else if (start_ok) cnt <= '0;
      else if (fire && sel == SW'(c) && cnt != '1) cnt <= cnt + 32'd1;
    assign o_word_cnt[c*32+:32] = cnt;
  end
`endif
endmodule

// File: tb/tb_axis_channel_dispatch.sv
// tb_axis_channel_dispatch: directed self-checking bench for axis_channel_dispatch
module tb_axis_channel_dispatch;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, tx_done = 1'b0;
  logic s_tvalid = 1'b0, s_tlast = 1'b0;
  logic [3:0] ch_en = '0, m_tready = 4'hF;
  logic [15:0] pkt_num = '0;
  logic [63:0] s_tdata = '0;
  logic s_tready, busy, done, err;
  logic [255:0] m_tdata;
  logic [3:0] m_tlast, m_tvalid;
`ifdef DISPATCH_STATS_EN
  logic [127:0] word_cnt;
`endif
  int checks = 0, errors = 0;
  axis_channel_dispatch dut (
    .s_axis_aclk(clk), .s_axis_aresetn(rst_n), .i_start(start), .i_ch_en(ch_en),
    .i_pkt_num(pkt_num), .i_tx_done(tx_done), .s_axis_tready(s_tready),
    .s_axis_tdata(s_tdata), .s_axis_tlast(s_tlast), .s_axis_tvalid(s_tvalid),
    .m_axis_tready(m_tready), .m_axis_tdata(m_tdata), .m_axis_tlast(m_tlast),
    .m_axis_tvalid(m_tvalid), .o_busy(busy), .o_done(done), .o_err(err)
`ifdef DISPATCH_STATS_EN
    , .o_word_cnt(word_cnt)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic start_job(input logic [3:0] mask, input logic [15:0] n);
    start = 1'b1;
    ch_en = mask;
    pkt_num = n;
    @(negedge clk);
    start = 1'b0;
  endtask
  task automatic send_pkt(input int nb, input int ch, input logic [63:0] base);
    for (int b = 0; b < nb; b++) begin
      s_tvalid = 1'b1;
      s_tlast = (b == nb - 1);
      s_tdata = base + 64'(b);
      #1;
      chk("route_tvalid", m_tvalid, 64'(4'b0001 << ch));
      chk("route_tready", s_tready, 1);
      chk("route_tdata", m_tdata[ch*64+:64], base + 64'(b));
      chk("route_tlast", m_tlast[ch], (b == nb - 1));
      @(negedge clk);
    end
  endtask
  task automatic finish_job();
    s_tvalid = 1'b1;
    s_tlast = 1'b0;
    #1;
    chk("drain_tready", s_tready, 0);
    chk("drain_tvalid", m_tvalid, 0);
    chk("drain_busy", busy, 1);
    chk("drain_done", done, 0);
    s_tvalid = 1'b0;
    @(negedge clk);
    chk("drain_wait_done", done, 0);
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    #1;
    chk("done_pulse", done, 1);
    chk("done_busy", busy, 1);
    @(negedge clk);
    #1;
    chk("done_end", done, 0);
    chk("idle_busy", busy, 0);
    @(negedge clk);
  endtask
  initial begin
    #1;
    chk("rst_tready", s_tready, 0);
    chk("rst_tvalid", m_tvalid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    #1;
    chk("idle_txdone_busy", busy, 0);
    chk("idle_txdone_done", done, 0);
    @(negedge clk);
    start_job(4'b1111, 16'd8);
    for (int p = 0; p < 8; p++) send_pkt(2, p % 4, 64'h1000 + 64'(p * 16));
    finish_job();
`ifdef DISPATCH_STATS_EN
    for (int c = 0; c < 4; c++) chk("word_cnt", word_cnt[c*32+:32], 4);
`endif
    start_job(4'b1010, 16'd3);
    start = 1'b1;
    ch_en = 4'b0001;
    pkt_num = 16'd1;
    #1;
    chk("restart_busy", busy, 1);
    chk("restart_tvalid", m_tvalid, 0);
    @(negedge clk);
    start = 1'b0;
    send_pkt(3, 1, 64'h2000);
    send_pkt(3, 3, 64'h2100);
    send_pkt(3, 1, 64'h2200);
    finish_job();
    start_job(4'b1000, 16'd3);
    for (int p = 0; p < 3; p++) send_pkt(1, 3, 64'h3000 + 64'(p));
    finish_job();
    start_job(4'b1111, 16'd1);
    send_pkt(1, 0, 64'h4000);
    finish_job();
    start_job(4'b1111, 16'd1);
    s_tvalid = 1'b1;
    s_tlast = 1'b0;
    s_tdata = 64'h5000;
    #1;
    chk("stall_b0_tvalid", m_tvalid, 64'h1);
    @(negedge clk);
    s_tdata = 64'h5001;
    m_tready = 4'b1110;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("stall_tready", s_tready, 0);
      chk("stall_tvalid", m_tvalid, 64'h1);
      chk("stall_tdata", m_tdata[63:0], 64'h5001);
      @(negedge clk);
    end
    m_tready = 4'hF;
    send_pkt(3, 0, 64'h5001);
    finish_job();
    start_job(4'b0000, 16'd5);
    #1;
    chk("err_set", err, 1);
    chk("err_busy", busy, 0);
    @(negedge clk);
    #1;
    chk("err_sticky", err, 1);
    chk("err_idle_busy", busy, 0);
    @(negedge clk);
    start_job(4'b0001, 16'd0);
    s_tvalid = 1'b1;
    #1;
    chk("zero_done", done, 1);
    chk("zero_busy", busy, 1);
    chk("zero_err_clr", err, 0);
    chk("zero_tready", s_tready, 0);
    chk("zero_tvalid", m_tvalid, 0);
`ifdef DISPATCH_STATS_EN
    for (int c = 0; c < 4; c++) chk("word_cnt_clr", word_cnt[c*32+:32], 0);
`endif
    @(negedge clk);
    s_tvalid = 1'b0;
    #1;
    chk("zero_done_end", done, 0);
    chk("zero_idle", busy, 0);
    @(negedge clk);
    start_job(4'b0110, 16'd2);
    send_pkt(1, 1, 64'h6000);
    s_tvalid = 1'b1;
    s_tlast = 1'b0;
    s_tdata = 64'h6100;
    #1;
    chk("rst_pkt_b0", m_tvalid, 64'h4);
    @(negedge clk);
    s_tdata = 64'h6101;
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_tready", s_tready, 0);
    chk("midrst_tvalid", m_tvalid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_err", err, 0);
`ifdef DISPATCH_STATS_EN
    chk("midrst_word_cnt", word_cnt, 0);
`endif
    s_tvalid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start_job(4'b1100, 16'd1);
    send_pkt(1, 2, 64'h7000);
    finish_job();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end
endmodule
